// File: rtl/calc_enc_sync_if.sv
// Opcode handshake between the button encoder and the calculator datapath.
interface calc_enc_sync_if;
    logic       op_ready;
    logic [3:0] alu_op;
    logic       op_valid;
    logic       op_drop;

    modport master (input op_ready, output alu_op, output op_valid, output op_drop);
    modport slave  (output op_ready, input alu_op, input op_valid, input op_drop);
endinterface

// File: rtl/calc_enc_sync.sv
// Button synchroniser/debouncer and registered ALU-opcode encoder with a
// single-entry valid/ready output and a sticky overflow flag.
module calc_enc_sync_db #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_w;

    assign sync_w   = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

    // Counter only runs while the synchronised level disagrees; any agreeing
    // cycle restarts qualification from zero.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_w != stable_q) begin
            if (cnt_q == CNT_LAST) stable_d = sync_w;
            else                   cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end
endmodule

module calc_enc_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btnl_i,
    input  logic             btnr_i,
    input  logic             btnd_i,
    input  logic             btnc_i,
    calc_enc_sync_if.master  op_if,
    output logic [3:0]       btn_db_o
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    logic [3:0] raw_w, pol_w, db_w;
    logic       prev_c_q;
    logic       rise_w;
    state_e     state_q, state_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic       drop_q, drop_d;

    assign raw_w = {btnl_i, btnr_i, btnd_i, btnc_i};
    assign pol_w = BTN_ACTIVE_HIGH ? raw_w : ~raw_w;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        calc_enc_sync_db #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (pol_w[g]),
            .stable_o (db_w[g])
        );
    end

    assign btn_db_o = db_w;
    assign rise_w   = db_w[0] & ~prev_c_q;

    function automatic logic [3:0] encode(input logic [2:0] lrd);
        case (lrd)
            3'b000:  encode = 4'b0000;
            3'b001:  encode = 4'b0101;
            3'b010:  encode = 4'b0100;
            3'b011:  encode = 4'b1100;
            3'b100:  encode = 4'b0010;
            3'b101:  encode = 4'b0111;
            3'b110:  encode = 4'b0110;
            default: encode = 4'b1111;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        alu_op_d = alu_op_q;
        drop_d   = drop_q;
        case (state_q)
            EMPTY: begin
                if (rise_w) begin
                    alu_op_d = encode(db_w[3:1]);
                    state_d  = FULL;
                end
            end
            FULL: begin
                // Accept and reload in the same cycle keeps the slot occupied.
                if (rise_w && op_if.op_ready) alu_op_d = encode(db_w[3:1]);
                else if (rise_w)              drop_d   = 1'b1;
                else if (op_if.op_ready)      state_d  = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            alu_op_q <= 4'b0000;
            drop_q   <= 1'b0;
            prev_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
            drop_q   <= drop_d;
            prev_c_q <= db_w[0];
        end
    end

    assign op_if.alu_op   = alu_op_q;
    assign op_if.op_valid = (state_q == FULL);
    assign op_if.op_drop  = drop_q;
endmodule

// File: tb/tb_calc_enc_sync.sv
// Scoreboard bench: one active-high instance for the handshake scenarios and
// one active-low instance for the polarity scenario.
module tb_calc_enc_sync;
    localparam int SS = 2;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnl = 0, btnr = 0, btnd = 0, btnc = 0;
    logic bl_n = 1, br_n = 1, bd_n = 1, bc_n = 1;
    logic [3:0] db_a, db_b;

    calc_enc_sync_if if_a ();
    calc_enc_sync_if if_b ();

    always #5 clk = ~clk;

    calc_enc_sync #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .BTN_ACTIVE_HIGH(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .btnl_i(btnl), .btnr_i(btnr), .btnd_i(btnd), .btnc_i(btnc),
        .op_if(if_a), .btn_db_o(db_a)
    );

    calc_enc_sync #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .BTN_ACTIVE_HIGH(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .btnl_i(bl_n), .btnr_i(br_n), .btnd_i(bd_n), .btnc_i(bc_n),
        .op_if(if_b), .btn_db_o(db_b)
    );

    int n_run = 0, n_fail = 0, n_acc = 0;
    logic [3:0] sb_q[$];
    logic [3:0] enc_tab [8] = '{4'h0, 4'h5, 4'h4, 4'hC, 4'h2, 4'h7, 4'h6, 4'hF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every accepted opcode must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && if_a.op_valid && if_a.op_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected", sb_q.size(), 1);
            else begin
                chk("sb_alu_op", if_a.alu_op, sb_q.pop_front());
                n_acc++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] lrd, input bit expect_load);
        {btnl, btnr, btnd} = lrd;
        cyc(10);
        if (expect_load) sb_q.push_back(enc_tab[lrd]);
        btnc = 1'b1;
        cyc(10);
        btnc = 1'b0;
        cyc(10);
    endtask

    bit saw_db, saw_v;

    initial begin
        if_a.op_ready = 1'b0;
        if_b.op_ready = 1'b0;
        cyc(3);
        chk("rst_alu_op", if_a.alu_op, 4'h0);
        chk("rst_valid", if_a.op_valid, 1'b0);
        chk("rst_drop", if_a.op_drop, 1'b0);
        chk("rst_db", db_a, 4'h0);
        chk("rst_db_b", db_b, 4'h0);
        rst = 1'b0;
        cyc(2);

        // Reset mid-debounce, then re-qualification latency.
        btnc = 1'b1;
        cyc(4);
        rst = 1'b1;
        #1;
        chk("midrst_valid", if_a.op_valid, 1'b0);
        chk("midrst_db", db_a, 4'h0);
        chk("midrst_alu_op", if_a.alu_op, 4'h0);
        @(posedge clk); #1 rst = 1'b0;
        cyc(6);
        chk("lat_edge6_valid", if_a.op_valid, 1'b0);
        sb_q.push_back(4'h0);
        cyc(1);
        chk("lat_edge7_valid", if_a.op_valid, 1'b1);
        chk("lat_drop", if_a.op_drop, 1'b0);
        btnc = 1'b0;
        if_a.op_ready = 1'b1;
        cyc(10);

        // Encoding sweep, always ready.
        for (int i = 0; i < 8; i++) press(3'(i), 1'b1);

        // Glitch rejection: 3-cycle pulse then 4-cycle pulse.
        {btnl, btnr, btnd} = 3'b000;
        cyc(10);
        saw_db = 0; saw_v = 0;
        btnc = 1'b1; cyc(3); btnc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            saw_db |= db_a[0]; saw_v |= if_a.op_valid;
        end
        chk("glitch3_db", saw_db, 1'b0);
        chk("glitch3_valid", saw_v, 1'b0);
        saw_db = 0; saw_v = 0;
        sb_q.push_back(4'h0);
        btnc = 1'b1; cyc(4); btnc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc(1);
            saw_db |= db_a[0]; saw_v |= if_a.op_valid;
        end
        chk("glitch4_db", saw_db, 1'b1);
        chk("glitch4_valid", saw_v, 1'b1);
        cyc(5);

        // Simultaneous accept and reload.
        if_a.op_ready = 1'b0;
        press(3'b011, 1'b1);
        chk("sim_full_xor", if_a.alu_op, 4'hC);
        {btnl, btnr, btnd} = 3'b100;
        cyc(10);
        sb_q.push_back(4'h2);
        btnc = 1'b1;
        cyc(6);
        chk("sim_db_c", db_a[0], 1'b1);
        if_a.op_ready = 1'b1;
        cyc(1);
        if_a.op_ready = 1'b0;
        chk("sim_valid", if_a.op_valid, 1'b1);
        chk("sim_alu_op", if_a.alu_op, 4'h2);
        chk("sim_drop", if_a.op_drop, 1'b0);
        btnc = 1'b0;
        cyc(10);
        if_a.op_ready = 1'b1;
        cyc(1);
        if_a.op_ready = 1'b0;

        // Backpressure and sticky drop.
        press(3'b010, 1'b1);
        chk("bp_valid", if_a.op_valid, 1'b1);
        chk("bp_alu_op", if_a.alu_op, 4'h4);
        chk("bp_drop0", if_a.op_drop, 1'b0);
        press(3'b101, 1'b0);
        chk("bp_keep_alu_op", if_a.alu_op, 4'h4);
        chk("bp_drop1", if_a.op_drop, 1'b1);
        chk("bp_valid2", if_a.op_valid, 1'b1);
        if_a.op_ready = 1'b1;
        cyc(1);
        if_a.op_ready = 1'b0;
        chk("bp_accept_valid", if_a.op_valid, 1'b0);
        chk("bp_drop_sticky", if_a.op_drop, 1'b1);

        // Active-low instance: idle-high raw inputs never committed.
        chk("pol_idle_valid", if_b.op_valid, 1'b0);
        chk("pol_idle_db", db_b, 4'h0);
        br_n = 1'b0; bd_n = 1'b0;
        cyc(10);
        bc_n = 1'b0;
        cyc(10);
        chk("pol_valid", if_b.op_valid, 1'b1);
        chk("pol_alu_op", if_b.alu_op, 4'hC);
        chk("pol_db", db_b, 4'b0111);

        cyc(5);
        chk("sb_empty", sb_q.size(), 0);
        chk("acc_count", n_acc, 13);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_enc_sync.md
# calc_enc_sync

Registered, debounced successor to the combinational calculator encoder. Synchronises and debounces the four board buttons (btnl, btnr, btnd, btnc), encodes the debounced btnl/btnr/btnd state into a 4-bit ALU opcode, and presents it on a valid/ready interface each time btnc is pressed. It sits between the board buttons and the calculator datapath/ALU control.

## Interface
- SYNC_STAGES, 2: synchroniser flip-flops per button, legal range ≥2.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its debounced value before that value flips, legal range ≥1.
- BTN_ACTIVE_HIGH, 1: 1 means raw buttons are active-high; 0 means all four raw inputs are inverted at entry.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btnl  in  1  raw left button, asynchronous to clk.
- btnr  in  1  raw right button, asynchronous to clk.
- btnd  in  1  raw down button, asynchronous to clk.
- btnc  in  1  raw centre (commit) button, asynchronous to clk.
- op_ready  in  1  downstream accepts the opcode when high with op_valid.
- alu_op  out  4  registered opcode.
- op_valid  out  1  alu_op holds an unaccepted opcode.
- op_drop  out  1  sticky flag: a commit was lost because the interface was busy.
- btn_db  out  4  debounced button levels {btnl, btnr, btnd, btnc}, after the polarity stage.

## Operation
- Per button: optional inversion (BTN_ACTIVE_HIGH=0), then a SYNC_STAGES flip-flop chain, then a debouncer.
- Debouncer: counter of width clog2(DEBOUNCE_CYCLES+1).
  - While sync == stable, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - At the edge where the counter equals DEBOUNCE_CYCLES-1 and the inputs still differ, stable flips and the counter clears.
  - Any cycle with sync == stable clears the counter, so glitches shorter than DEBOUNCE_CYCLES never reach stable.
- Commit event: rise = stable_c & ~prev_c, where prev_c is stable_c registered by one cycle. Only the press is a commit event; releasing btnc does nothing.
- Encoding of debounced {l,r,d}:
  - 000 → 0000 (SRL)
  - 001 → 0101 (SLL)
  - 010 → 0100 (ADD)
  - 011 → 1100 (XOR)
  - 100 → 0010 (NOR)
  - 101 → 0111 (SUB)
  - 110 → 0110 (MULT)
  - 111 → 1111 (NAND)
- Output FSM with two states, EMPTY (op_valid=0) and FULL (op_valid=1).
  - EMPTY + rise: load alu_op from the encoding of the current stable l/r/d, go to FULL.
  - FULL + op_ready without rise: go to EMPTY. alu_op keeps its last value.
  - FULL + op_ready + rise in the same cycle: load the new opcode and stay FULL. Nothing is dropped.
  - FULL + no op_ready + rise: keep the old alu_op, set op_drop=1, stay FULL.
- While FULL, alu_op stays stable until accepted.
- op_drop is cleared only by rst.

## Timing
- Reset values:
  - alu_op = 0000, op_valid = 0, op_drop = 0, btn_db = 0000.
  - All synchroniser flip-flops, counters and prev_c are 0.
  - These values apply in the post-polarity domain, so with BTN_ACTIVE_HIGH=0 a raw-high (idle) input reads as released.
- rst takes effect immediately and asynchronously. It aborts any debounce in progress and discards a pending opcode. A button held through reset release must re-qualify through the full debounce before btn_db shows it.
- Commit latency: number the first rising edge at which btnc is sampled pressed as edge 1. If btnc stays pressed, op_valid is first high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- l/r/d are sampled from stable values at the load edge. Operand buttons must already be debounced when btnc qualifies.
- op_valid and alu_op are direct register outputs with no combinational path from op_ready.
- Throughput: at most one commit per press. Minimum spacing between commits is 2·DEBOUNCE_CYCLES+1 cycles.

## Test plan
- Reset values: assert rst mid-debounce (counter = 2, DEBOUNCE_CYCLES=4, SYNC_STAGES=2) → all outputs 0 immediately. After release, btnc held high gives op_valid exactly 7 edges later.
- Encoding sweep: op_ready=1. For each {l,r,d} 000…111, hold l/r/d for 10 cycles, then press btnc for 10 cycles → alu_op = 0000, 0101, 0100, 1100, 0010, 0111, 0110, 1111, each with a one-cycle op_valid.
- Glitch rejection: 3-cycle btnc pulse with DEBOUNCE_CYCLES=4 → btn_db[0] stays 0 and op_valid stays 0. A 4-cycle pulse → btn_db[0] rises and op_valid rises.
- Backpressure: op_ready=0, commit ADD (010) → op_valid=1, alu_op=0100. Second commit SUB (101) → alu_op stays 0100 and op_drop=1. Raise op_ready → op_valid drops the next cycle; op_drop stays 1.
- Simultaneous accept and load: FULL with XOR (1100) while op_ready=1 in the rise cycle of a NOR commit → op_valid stays 1, alu_op=0010, op_drop stays 0.
- Polarity: BTN_ACTIVE_HIGH=0, idle raw inputs all 1 → no commit. Drive raw btnr=0 and btnd=0, then raw btnc=0 → alu_op=1100.
